layer_flag_sequencer: RTL and testbench
=======================================

LAYER_FLAG_SEQUENCER -- requirements
Module: layer_flag_sequencer

Interface
REQ-001 SHALL have parameter: N_STG, default 7, number of downstream stages sequenced (flags width).
REQ-002 SHALL have parameter: LAT, default 4, per-stage pipeline latency in cycles; legal range 1..9.
REQ-003 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port: start  input  1  one-cycle pulse: previous layer has data ready.
REQ-006 SHALL have port: src_done  input  1  one-cycle pulse: last input word of the layer accepted.
REQ-007 SHALL have port: temp_zero  output  1  run enable for the first stage; drives the stall controller's first gate.
REQ-008 SHALL have port: flags  output  N_STG  per-stage enable; flags[k] means stage k+1 holds valid data.
REQ-009 SHALL have port: finish_layer  output  1  one-cycle pulse when the pipeline has fully drained.
REQ-010 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, FILL, RUN, DRAIN, DONE.
REQ-012 SHALL leave IDLE for FILL on start=1, clearing the 6-bit cycle counter cnt to 0.
REQ-013 SHALL hold temp_zero=1 in FILL and RUN, and 0 in all other states.
REQ-014 SHALL, in FILL, increment cnt each cycle and set flags[k] in the cycle after cnt reaches (k+1)*LAT-1; flags set while filling stay set.
REQ-015 SHALL go from FILL to RUN in the cycle flags[N_STG-1] sets, with flags all ones.
REQ-016 SHALL latch a src_done that arrives in FILL, finish FILL unchanged, then go from FILL directly to DRAIN (skipping RUN).
REQ-017 SHALL, on src_done in RUN, enter DRAIN next cycle with cnt=0 and temp_zero=0.
REQ-018 SHALL, in DRAIN, increment cnt each cycle and clear flags[k] in the cycle after cnt reaches (k+1)*LAT-1 (lowest stage empties first).
REQ-019 SHALL leave DRAIN for DONE in the cycle flags becomes all zero.
REQ-020 SHALL pulse finish_layer=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-021 SHALL accept a start in DONE, going directly to FILL and so sequencing back-to-back layers with no IDLE cycle.
REQ-022 SHALL ignore start in FILL, RUN and DRAIN, and ignore src_done in IDLE, DRAIN and DONE.
REQ-023 SHALL keep cnt at 6 bits, never wrap it within a phase (max (N_STG)*LAT-1 = 62), and compare it combinationally against the constant products.
REQ-024 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-025 SHALL, with rst=0 at a rising edge, enter IDLE with cnt=0, flags=0, temp_zero=0, finish_layer=0, busy=0.
REQ-026 SHALL abort immediately on a reset mid-layer (any state), with no finish_layer pulse and the latched src_done cleared.
REQ-027 SHALL, in the cycle reset releases, have start sampled normally.

Structure
REQ-028 SHALL place the FSM state encoding (3-bit enum) and the defaults N_STG=7 and LAT=4 in the shared accelerator package, which the stall controllers also use.
REQ-029 SHALL have one sub-module, stage_flag_reg: a per-stage set/clear flop instantiated N_STG times, with set/clear decode from the FSM.
REQ-030 SHALL connect flags and temp_zero directly to the stall controller's flag and temp_zero inputs, and finish_layer to that controller's finish_layer.

Verification
REQ-031 SHALL verify: reset then start at cycle 0 with LAT=4 -> flags[0] rises at cycle 5, flags[6] at cycle 29, RUN at cycle 29, temp_zero high from cycle 1.
REQ-032 SHALL verify: src_done 10 cycles into RUN -> temp_zero drops next cycle, flags[0] clears 4 cycles later, flags[6] clears 28 cycles later, finish_layer is a single pulse 1 cycle after that.
REQ-033 SHALL verify: src_done at cycle 12 of FILL -> all 7 flags still set before DRAIN starts, RUN is never entered, and only one finish_layer pulse.
REQ-034 SHALL verify: start asserted in the DONE cycle -> FILL on the next cycle, busy never drops, cnt restarts at 0.
REQ-035 SHALL verify: rst=0 asserted mid-DRAIN with flags=7'b1111000 -> next cycle flags=0, state IDLE, no finish_layer pulse.
REQ-036 SHALL verify: spurious start during RUN and src_done during IDLE -> no state change, outputs unchanged.

Source files
------------

// File: rtl/layer_flag_sequencer_pkg.sv
// Shared accelerator definitions: sequencer state encoding and default pipeline geometry.
package layer_flag_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int N_STG_DEF = 7;
   localparam int LAT_DEF   = 4;
   localparam int CNT_W     = 6;

endpackage

// File: rtl/layer_flag_sequencer_stage_flag_reg.sv
// One stage-valid flop; clear wins over set so a drain decode can never be masked.
module stage_flag_reg (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_set,
   input  logic i_clr,
   output logic o_q
);

   logic r_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst)     r_q <= 1'b0;
      else if (i_clr) r_q <= 1'b0;
      else if (i_set) r_q <= 1'b1;
   end

   assign o_q = r_q;

endmodule

// File: rtl/layer_flag_sequencer.sv
// Sequences per-stage valid flags through fill, run and drain of one layer,
// with a registered run enable, busy and a one-cycle finish pulse.
module layer_flag_sequencer
   import layer_flag_sequencer_pkg::*;
#(
   parameter int N_STG = N_STG_DEF,
   parameter int LAT   = LAT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             src_done,
   output logic             temp_zero,
   output logic [N_STG-1:0] flags,
   output logic             finish_layer,
   output logic             busy
);

   state_t             r_state, w_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_src_lat, w_src_lat_nxt;
   logic               r_temp_zero, r_finish, r_busy;
   logic [N_STG-1:0]   w_hit, w_set, w_clr, w_flags;

   genvar k;
   generate
      for (k = 0; k < N_STG; k++) begin : g_stage
         localparam logic [CNT_W-1:0] THR = CNT_W'((k + 1) * LAT - 1);
         assign w_hit[k] = (r_cnt == THR);
         assign w_set[k] = (r_state == FILL)  && w_hit[k];
         assign w_clr[k] = (r_state == DRAIN) && w_hit[k];
         stage_flag_reg u_flag (
            .i_clk (clk),
            .i_rst (rst),
            .i_set (w_set[k]),
            .i_clr (w_clr[k]),
            .o_q   (w_flags[k])
         );
      end
   endgenerate

   always_comb begin
      w_nxt         = r_state;
      w_cnt_nxt     = r_cnt;
      w_src_lat_nxt = r_src_lat;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nxt     = FILL;
               w_cnt_nxt = '0;
            end
         end
         FILL: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (src_done) w_src_lat_nxt = 1'b1;
            // Last stage fills this edge; an early src_done skips RUN entirely.
            if (w_hit[N_STG-1]) begin
               w_nxt         = (r_src_lat || src_done) ? DRAIN : RUN;
               w_cnt_nxt     = '0;
               w_src_lat_nxt = 1'b0;
            end
         end
         RUN: begin
            if (src_done) begin
               w_nxt     = DRAIN;
               w_cnt_nxt = '0;
            end
         end
         DRAIN: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (~|w_flags) begin
               w_nxt     = DONE;
               w_cnt_nxt = '0;
            end
         end
         DONE: begin
            w_nxt     = start ? FILL : IDLE;
            w_cnt_nxt = '0;
         end
         default: begin
            w_nxt     = IDLE;
            w_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_src_lat   <= 1'b0;
         r_temp_zero <= 1'b0;
         r_finish    <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_nxt;
         r_cnt       <= w_cnt_nxt;
         r_src_lat   <= w_src_lat_nxt;
         r_temp_zero <= (w_nxt == FILL) || (w_nxt == RUN);
         r_finish    <= (w_nxt == DONE);
         r_busy      <= (w_nxt != IDLE);
      end
   end

   assign temp_zero    = r_temp_zero;
   assign flags        = w_flags;
   assign finish_layer = r_finish;
   assign busy         = r_busy;

endmodule

// File: tb/tb_layer_flag_sequencer.sv
// Directed bench for the layer flag sequencer: fill/run/drain timing, early src_done,
// back-to-back layers, mid-layer reset and ignored inputs.
module tb_layer_flag_sequencer;
   import layer_flag_sequencer_pkg::*;

   localparam int N = 7;
   localparam int L = 4;

   logic         clk = 1'b0;
   logic         rst, start, src_done;
   logic         temp_zero, finish_layer, busy;
   logic [N-1:0] flags;

   int errs, checks, cyc, fin_cnt;
   bit saw_run;

   always #5 clk = ~clk;

   layer_flag_sequencer #(.N_STG(N), .LAT(L)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .src_done     (src_done),
      .temp_zero    (temp_zero),
      .flags        (flags),
      .finish_layer (finish_layer),
      .busy         (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (finish_layer) fin_cnt++;
      if (dut.r_state == RUN) saw_run = 1'b1;
   endtask

   function automatic logic [31:0] st();
      return 32'(dut.r_state);
   endfunction

   initial begin
      errs = 0; checks = 0; cyc = 0; fin_cnt = 0; saw_run = 1'b0;
      rst = 1'b0; start = 1'b0; src_done = 1'b0;
      step(); step();
      chk("rst_state", st(), 32'(IDLE));
      chk("rst_cnt", 32'(dut.r_cnt), 0);
      chk("rst_flags", 32'(flags), 0);
      chk("rst_tz", 32'(temp_zero), 0);
      chk("rst_fin", 32'(finish_layer), 0);
      chk("rst_busy", 32'(busy), 0);

      // src_done while idle does nothing
      rst = 1'b1; src_done = 1'b1; step(); src_done = 1'b0;
      chk("idle_src_state", st(), 32'(IDLE));
      chk("idle_src_busy", 32'(busy), 0);
      chk("idle_src_flags", 32'(flags), 0);

      // layer 1: start sampled at the end of cycle 0
      cyc = 0; start = 1'b1; step(); start = 1'b0;
      chk("l1_fill", st(), 32'(FILL));
      chk("l1_tz1", 32'(temp_zero), 1);
      chk("l1_busy", 32'(busy), 1);
      chk("l1_cnt0", 32'(dut.r_cnt), 0);
      while (cyc < 29) begin
         step();
         if (cyc == 4)  chk("l1_f_c4", 32'(flags), 32'h00);
         if (cyc == 5)  chk("l1_f_c5", 32'(flags), 32'h01);
         if (cyc == 28) begin
            chk("l1_f_c28", 32'(flags), 32'h3f);
            chk("l1_st_c28", st(), 32'(FILL));
         end
      end
      chk("l1_run_c29", st(), 32'(RUN));
      chk("l1_f_c29", 32'(flags), 32'h7f);
      chk("l1_tz_c29", 32'(temp_zero), 1);

      // spurious start in RUN
      while (cyc < 32) step();
      start = 1'b1; step(); start = 1'b0;
      chk("run_start_st", st(), 32'(RUN));
      chk("run_start_f", 32'(flags), 32'h7f);
      chk("run_start_tz", 32'(temp_zero), 1);
      chk("run_start_fin", 32'(finish_layer), 0);

      // src_done 10 cycles into RUN (cycle 39)
      while (cyc < 39) step();
      src_done = 1'b1; step(); src_done = 1'b0;
      chk("l1_drain", st(), 32'(DRAIN));
      chk("l1_drain_tz", 32'(temp_zero), 0);
      chk("l1_drain_cnt", 32'(dut.r_cnt), 0);
      chk("l1_drain_f", 32'(flags), 32'h7f);
      fin_cnt = 0;
      while (cyc < 69) begin
         if (cyc == 50) src_done = 1'b1;
         step();
         src_done = 1'b0;
         if (cyc == 43) chk("dr_f_c43", 32'(flags), 32'h7f);
         if (cyc == 44) chk("dr_f_c44", 32'(flags), 32'h7e);
         if (cyc == 52) chk("dr_f_c52", 32'(flags), 32'h78);
         if (cyc == 67) chk("dr_f_c67", 32'(flags), 32'h40);
         if (cyc == 68) begin
            chk("dr_f_c68", 32'(flags), 32'h00);
            chk("dr_st_c68", st(), 32'(DRAIN));
            chk("dr_fin_c68", 32'(finish_layer), 0);
         end
      end
      chk("l1_done", st(), 32'(DONE));
      chk("l1_fin", 32'(finish_layer), 1);
      chk("l1_done_busy", 32'(busy), 1);

      // back-to-back: start in the DONE cycle
      start = 1'b1; step(); start = 1'b0;
      chk("b2b_fill", st(), 32'(FILL));
      chk("b2b_cnt", 32'(dut.r_cnt), 0);
      chk("b2b_busy", 32'(busy), 1);
      chk("b2b_fin0", 32'(finish_layer), 0);
      chk("b2b_tz", 32'(temp_zero), 1);
      chk("l1_fin_cnt", 32'(fin_cnt), 1);

      // layer 2: FILL cycle 1 = 70, src_done in FILL cycle 12 = 81
      saw_run = 1'b0; fin_cnt = 0;
      while (cyc < 81) step();
      src_done = 1'b1; step(); src_done = 1'b0;
      while (cyc < 97) step();
      chk("l2_f_c97", 32'(flags), 32'h3f);
      chk("l2_st_c97", st(), 32'(FILL));
      step();
      chk("l2_drain", st(), 32'(DRAIN));
      chk("l2_drain_f", 32'(flags), 32'h7f);
      chk("l2_drain_tz", 32'(temp_zero), 0);
      while (cyc < 127) begin
         step();
         if (cyc == 102) chk("l2_f_c102", 32'(flags), 32'h7e);
         if (cyc == 126) begin
            chk("l2_f_c126", 32'(flags), 32'h00);
            chk("l2_st_c126", st(), 32'(DRAIN));
         end
      end
      chk("l2_done", st(), 32'(DONE));
      chk("l2_fin", 32'(finish_layer), 1);
      step();
      chk("l2_idle", st(), 32'(IDLE));
      chk("l2_fin0", 32'(finish_layer), 0);
      chk("l2_busy0", 32'(busy), 0);
      chk("l2_no_run", 32'(saw_run), 0);
      chk("l2_fin_cnt", 32'(fin_cnt), 1);

      // layer 3: reset mid-DRAIN with flags = 1111000
      fin_cnt = 0;
      start = 1'b1; step(); start = 1'b0;
      while (cyc < 157) step();
      chk("l3_run", st(), 32'(RUN));
      src_done = 1'b1; step(); src_done = 1'b0;
      while (cyc < 171) step();
      chk("l3_f_pre", 32'(flags), 32'h78);
      chk("l3_st_pre", st(), 32'(DRAIN));
      rst = 1'b0; step();
      chk("l3_rst_f", 32'(flags), 0);
      chk("l3_rst_st", st(), 32'(IDLE));
      chk("l3_rst_busy", 32'(busy), 0);
      chk("l3_rst_tz", 32'(temp_zero), 0);
      chk("l3_rst_cnt", 32'(dut.r_cnt), 0);
      chk("l3_fin_cnt", 32'(fin_cnt), 0);

      // layer 4: start on the release edge; latched src_done must not survive reset
      rst = 1'b1; start = 1'b1; step(); start = 1'b0;
      chk("rel_fill", st(), 32'(FILL));
      while (cyc < 176) step();
      src_done = 1'b1; step(); src_done = 1'b0;
      while (cyc < 181) step();
      rst = 1'b0; step(); rst = 1'b1;
      chk("l4_rst_st", st(), 32'(IDLE));
      start = 1'b1; step(); start = 1'b0;
      while (cyc < 211) step();
      chk("l4_run", st(), 32'(RUN));
      chk("l4_tz", 32'(temp_zero), 1);
      chk("l4_f", 32'(flags), 32'h7f);
      chk("l4_fin_cnt", 32'(fin_cnt), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
